// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: operation codes, FSM
// state encoding and the legality check for operation codes.
// Optional feature macro: SHIFT_ROTATE_EN (enables FUNC_ROL / FUNC_ROR).
package shift_pkg;

    localparam logic [3:0] FUNC_LLS = 4'd0;
    localparam logic [3:0] FUNC_LRS = 4'd1;
    localparam logic [3:0] FUNC_ALS = 4'd2;
    localparam logic [3:0] FUNC_ARS = 4'd3;
    localparam logic [3:0] FUNC_ROL = 4'd4;
    localparam logic [3:0] FUNC_ROR = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Rotates only count as legal operations when the rotate option is built in.
    function automatic logic func_legal(input logic [3:0] func);
        case (func)
            FUNC_LLS, FUNC_LRS, FUNC_ALS, FUNC_ARS: func_legal = 1'b1;
`ifdef SHIFT_ROTATE_EN
            FUNC_ROL, FUNC_ROR:                     func_legal = 1'b1;
`endif
            default:                                func_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shift_unit_iter_if.sv
// Request/response bundle of the iterative shift unit.
// master = requester/consumer side, slave = shift unit side.
interface shift_unit_iter_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [SHAMT_W-1:0]    shamt;
    logic [3:0]            FuncCode;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] C;
    logic                  OverflowFlag;
    logic                  ErrFlag;

    modport master (
        output in_valid, A, shamt, FuncCode, out_ready,
        input  in_ready, out_valid, C, OverflowFlag, ErrFlag
    );

    modport slave (
        input  in_valid, A, shamt, FuncCode, out_ready,
        output in_ready, out_valid, C, OverflowFlag, ErrFlag
    );
endinterface

// File: rtl/shift_step.sv
// Combinational single step of the shift unit: shifts d by n (n <= STEP)
// according to func and reports whether any one-bit sub-step of an
// arithmetic left shift would flip the sign bit.
// Optional feature macro: SHIFT_ROTATE_EN (rotate datapath).
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STEP       = 1,
    localparam int SHAMT_W   = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [3:0]            func,
    input  logic [SHAMT_W-1:0]    n,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  ovf
);

    // Shift result per operation code; unknown codes pass the data through.
    always_comb begin
        q = d;
        case (func)
            FUNC_LLS, FUNC_ALS: q = d << n;
            FUNC_LRS:           q = d >> n;
            FUNC_ARS:           q = $signed(d) >>> n;
`ifdef SHIFT_ROTATE_EN
            FUNC_ROL:           q = (d << n) | (d >> (DATA_WIDTH - int'(n)));
            FUNC_ROR:           q = (d >> n) | (d << (DATA_WIDTH - int'(n)));
`endif
            default:            q = d;
        endcase
    end

    // Sign flips: after k one-bit steps the MSB holds d[W-1-k]; any change
    // between consecutive sub-steps is an overflow.
    always_comb begin
        ovf = 1'b0;
        if (func == FUNC_ALS) begin
            for (int k = 1; k <= STEP && k < DATA_WIDTH; k++) begin
                if (k <= int'(n) && d[DATA_WIDTH-1-k] != d[DATA_WIDTH-k])
                    ovf = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Iterative shift unit: accepts one request in IDLE, shifts STEP bits per
// cycle in SHIFT, and holds the result in DONE until the consumer takes it.
// Optional feature macro: SHIFT_ROTATE_EN (FUNC_ROL / FUNC_ROR legal).
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STEP       = 1,
    localparam int SHAMT_W   = $clog2(DATA_WIDTH)
) (
    input logic             clk,
    input logic             reset_n,
    shift_unit_iter_if.slave bus
);

    // STEP may equal DATA_WIDTH, which does not fit in SHAMT_W; since the
    // remaining count never exceeds DATA_WIDTH-1 the clamp is harmless.
    localparam int                 STEP_C = (STEP < DATA_WIDTH) ? STEP : DATA_WIDTH - 1;
    localparam logic [SHAMT_W-1:0] STEP_V = SHAMT_W'(STEP_C);

    state_t                state;
    logic [DATA_WIDTH-1:0] c;
    logic [SHAMT_W-1:0]    rem;
    logic [3:0]            func;
    logic                  ovf;
    logic                  err;
    logic                  out_valid;

    logic [SHAMT_W-1:0]    n;
    logic [DATA_WIDTH-1:0] step_q;
    logic                  step_ovf;

    // Bits to shift this cycle: min(STEP, remaining).
    always_comb begin
        n = (rem > STEP_V) ? STEP_V : rem;
    end

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP       (STEP)
    ) u_step (
        .d    (c),
        .func (func),
        .n    (n),
        .q    (step_q),
        .ovf  (step_ovf)
    );

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            c         <= '0;
            rem       <= '0;
            func      <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        c    <= bus.A;
                        func <= bus.FuncCode;
                        rem  <= bus.shamt;
                        ovf  <= 1'b0;
                        err  <= !func_legal(bus.FuncCode);
                        if (func_legal(bus.FuncCode) && bus.shamt != '0) begin
                            state <= SHIFT;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    c   <= step_q;
                    ovf <= ovf | step_ovf;
                    rem <= rem - n;
                    if (rem == n) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state == IDLE);
    assign bus.out_valid    = out_valid;
    assign bus.C            = c;
    assign bus.OverflowFlag = ovf;
    assign bus.ErrFlag      = err;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench for shift_unit_iter: a STEP=1 and a STEP=4 instance are
// driven with identical requests and checked against hand-computed results
// and per-instance latencies.
module tb_shift_unit_iter;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid_t = 1'b0;
    logic [15:0] a_t = '0;
    logic [3:0]  sh_t = '0;
    logic [3:0]  fc_t = '0;
    logic        ordy_t = 1'b0;

    shift_unit_iter_if #(.DATA_WIDTH(16)) b1 ();
    shift_unit_iter_if #(.DATA_WIDTH(16)) b4 ();

    assign b1.in_valid = in_valid_t;
    assign b1.A        = a_t;
    assign b1.shamt    = sh_t;
    assign b1.FuncCode = fc_t;
    assign b1.out_ready = ordy_t;
    assign b4.in_valid = in_valid_t;
    assign b4.A        = a_t;
    assign b4.shamt    = sh_t;
    assign b4.FuncCode = fc_t;
    assign b4.out_ready = ordy_t;

    shift_unit_iter #(.DATA_WIDTH(16), .STEP(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    shift_unit_iter #(.DATA_WIDTH(16), .STEP(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // One request on both instances; el1/el4 are cycles after the accept edge.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [3:0] sh,
                          input logic [3:0] fc, input logic [15:0] ec, input logic eo,
                          input logic ee, input int el1, input int el4);
        int l1, l4;
        @(negedge clk);
        a_t = a; sh_t = sh; fc_t = fc; in_valid_t = 1'b1;
        @(posedge clk); #1;
        in_valid_t = 1'b0;
        l1 = -1; l4 = -1;
        for (int t = 0; t < 40; t++) begin
            if (l1 < 0 && b1.out_valid) l1 = t;
            if (l4 < 0 && b4.out_valid) l4 = t;
            if (l1 >= 0 && l4 >= 0) break;
            @(posedge clk); #1;
        end
        chk({tag, " lat1"}, l1, el1);
        chk({tag, " lat4"}, l4, el4);
        chk({tag, " res1"}, {b1.OverflowFlag, b1.ErrFlag, b1.C}, {eo, ee, ec});
        chk({tag, " res4"}, {b4.OverflowFlag, b4.ErrFlag, b4.C}, {eo, ee, ec});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk({tag, " hold1"}, {b1.out_valid, b1.in_ready, b1.OverflowFlag, b1.ErrFlag, b1.C},
                {1'b1, 1'b0, eo, ee, ec});
            chk({tag, " hold4"}, {b4.out_valid, b4.in_ready, b4.OverflowFlag, b4.ErrFlag, b4.C},
                {1'b1, 1'b0, eo, ee, ec});
        end
        ordy_t = 1'b1;
        @(posedge clk); #1;
        ordy_t = 1'b0;
        chk({tag, " idle1"}, {b1.out_valid, b1.in_ready}, 2'b01);
        chk({tag, " idle4"}, {b4.out_valid, b4.in_ready}, 2'b01);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst1", {b1.out_valid, b1.in_ready, b1.OverflowFlag, b1.ErrFlag, b1.C}, {4'b0100, 16'h0});
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst4", {b4.out_valid, b4.in_ready, b4.OverflowFlag, b4.ErrFlag, b4.C}, {4'b0100, 16'h0});

        run_op("ars",     16'h8000, 4'd3,  FUNC_ARS, 16'hF000, 1'b0, 1'b0, 3, 1);
        run_op("als1",    16'h4001, 4'd1,  FUNC_ALS, 16'h8002, 1'b1, 1'b0, 1, 1);
        run_op("lls",     16'h00FF, 4'd4,  FUNC_LLS, 16'h0FF0, 1'b0, 1'b0, 4, 1);
        run_op("lrs15",   16'hF000, 4'd15, FUNC_LRS, 16'h0001, 1'b0, 1'b0, 15, 4);
        run_op("lrs0",    16'h1234, 4'd0,  FUNC_LRS, 16'h1234, 1'b0, 1'b0, 0, 0);
        run_op("als4",    16'h0F00, 4'd4,  FUNC_ALS, 16'hF000, 1'b1, 1'b0, 4, 1);
        run_op("alsneg",  16'hFFF0, 4'd3,  FUNC_ALS, 16'hFF80, 1'b0, 1'b0, 3, 1);
        run_op("alssty",  16'h5000, 4'd2,  FUNC_ALS, 16'h4000, 1'b1, 1'b0, 2, 1);
        run_op("ars_pos", 16'h7000, 4'd2,  FUNC_ARS, 16'h1C00, 1'b0, 1'b0, 2, 1);
        run_op("illegal", 16'hBEEF, 4'd5,  4'hF,     16'hBEEF, 1'b0, 1'b1, 0, 0);
`ifdef SHIFT_ROTATE_EN
        run_op("ror",     16'h0001, 4'd1,  FUNC_ROR, 16'h8000, 1'b0, 1'b0, 1, 1);
        run_op("rol",     16'h8001, 4'd4,  FUNC_ROL, 16'h0018, 1'b0, 1'b0, 4, 1);
`else
        run_op("ror",     16'h0001, 4'd1,  FUNC_ROR, 16'h0001, 1'b0, 1'b1, 0, 0);
        run_op("rol",     16'h8001, 4'd4,  FUNC_ROL, 16'h8001, 1'b0, 1'b1, 0, 0);
`endif

        // Reset in the middle of a long LLS: outputs clear at once, no result.
        @(negedge clk);
        a_t = 16'h0001; sh_t = 4'd10; fc_t = FUNC_LLS; in_valid_t = 1'b1;
        @(posedge clk); #1;
        in_valid_t = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midrst1", {b1.out_valid, b1.in_ready, b1.OverflowFlag, b1.ErrFlag, b1.C}, {4'b0100, 16'h0});
        chk("midrst4", {b4.out_valid, b4.in_ready, b4.OverflowFlag, b4.ErrFlag, b4.C}, {4'b0100, 16'h0});
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (b1.out_valid || b4.out_valid) seen = 1;
        end
        chk("no_result", seen, 0);
        run_op("after", 16'h00FF, 4'd4, FUNC_LLS, 16'h0FF0, 1'b0, 1'b0, 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_unit_iter.md
SHIFT_UNIT_ITER -- requirements
Module: shift_unit_iter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand/result width; SHALL be a power of two, at least 4.
REQ-002 Parameter STEP, default 1, bit positions shifted per SHIFT cycle; SHALL be in 1..DATA_WIDTH.
REQ-003 Derived constant SHAMT_W = $clog2(DATA_WIDTH), shift-amount width.
REQ-004 One clock; reset is asynchronous and active-low; ports SHALL be as follows.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  unit can accept; high only in IDLE.
REQ-009 A  in  DATA_WIDTH  signed operand.
REQ-010 shamt  in  SHAMT_W  shift amount, 0..DATA_WIDTH-1.
REQ-011 FuncCode  in  4  operation select, shared FUNC_* codes.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer takes result.
REQ-014 C  out  DATA_WIDTH  signed result.
REQ-015 OverflowFlag  out  1  arithmetic-left overflow.
REQ-016 ErrFlag  out  1  illegal FuncCode.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-018 Accept SHALL occur at an edge with in_valid && in_ready; it latches A, shamt and FuncCode, and sets remaining = shamt.
REQ-019 Accept transition: to SHIFT if shamt>0 and the code is legal; otherwise to DONE.
REQ-020 Each SHIFT cycle SHALL shift by n = min(STEP, remaining) and decrement remaining by n; when remaining reaches 0 the state SHALL move to DONE at that edge.
REQ-021 Latency: out_valid SHALL be high from edge N+ceil(shamt/STEP), where N is the accept edge (shamt=0 gives DONE at edge N).
REQ-022 Operations:
- FUNC_LLS: zero-fill left.
- FUNC_LRS: zero-fill right.
- FUNC_ALS: zero-fill left.
- FUNC_ARS: sign-fill right.
REQ-023 OverflowFlag SHALL be sticky per operation and set for FUNC_ALS only, when any single-bit step changes bit DATA_WIDTH-1; it SHALL be 0 for all other codes.
REQ-024 Illegal code: C=A, ErrFlag=1, OverflowFlag=0, DONE reached at the accept edge.
REQ-025 DONE SHALL hold C, flags and out_valid stable until out_ready; the edge with out_valid && out_ready SHALL return the FSM to IDLE.
REQ-026 in_ready SHALL be 0 in SHIFT and DONE; there is no accept in the same cycle as a result handoff.
REQ-027 C and flags SHALL update only at accept and SHIFT edges, never in DONE or IDLE.

Reset
REQ-028 reset_n low SHALL immediately force IDLE and clear C, OverflowFlag, ErrFlag, out_valid and remaining to 0; in_ready SHALL be 1 after reset.
REQ-029 Reset during SHIFT or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-030 With SHIFT_ROTATE_EN defined, FUNC_ROL and FUNC_ROR SHALL be legal, rotating by shamt at STEP bits per cycle with OverflowFlag=0.
REQ-031 Without SHIFT_ROTATE_EN, FUNC_ROL and FUNC_ROR SHALL be treated as illegal codes (REQ-024).

Structure
REQ-032 Shared package shift_pkg SHALL hold the FUNC_* codes (LLS, LRS, ALS, ARS, ROL, ROR) and the FSM state encoding.
REQ-033 One sub-module, shift_step, SHALL be combinational: a shift of up to STEP bits per FuncCode, returning the result and the per-step overflow.

Verification
REQ-034 ARS, A=0x8000, shamt=3, STEP=1: C=0xF000, OverflowFlag=0, out_valid at edge N+3.
REQ-035 ALS, A=0x4001, shamt=1: C=0x8002, OverflowFlag=1; LLS, A=0x00FF, shamt=4: C=0x0FF0, OverflowFlag=0.
REQ-036 STEP=4, LRS, A=0xF000, shamt=15: C=0x0001, out_valid at edge N+4; shamt=0: C=A at edge N.
REQ-037 ROR, A=0x0001, shamt=1: with SHIFT_ROTATE_EN gives C=0x8000, ErrFlag=0; without it gives C=0x0001, ErrFlag=1.
REQ-038 out_ready held low 3 cycles in DONE: C, flags and out_valid stable and in_ready=0; after handoff in_ready=1 next cycle.
REQ-039 reset_n pulsed low mid-SHIFT (LLS, shamt=10): all outputs 0 at once and no out_valid; after release a new request completes correctly.
